lp11_prt_tx: RTL and testbench

// - Downstream stage of the LP11 line-printer controller: takes each byte written to the printer data buffer,

---
 rtl/lp11_prt_tx.sv | 181 ++++++++++++++++++
 tb/tb_lp11_prt_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp11_prt_tx.sv
// LP11 printer transmit stage: byte FIFO feeding an 8N1 serial shifter with
// optional LF->CR/LF expansion, bit-7 stripping and CTS flow control.
module lp11_prt_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int CRLF       = 1,
    parameter int STRIP8     = 1
) (
    input  logic                          clk_p,
    input  logic                          sys_init_n,
    input  logic [7:0]                    char_i,
    input  logic                          char_stb,
    input  logic                          flush,
    input  logic                          clr_ovr,
    input  logic                          cts_n,
    output logic                          prt_rdy,
    output logic                          busy,
    output logic                          ovr,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          txd
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shift, shift_n;
    logic            txd_r, txd_n;
    logic            crdone, crdone_n;
    logic            pop;
    logic            push;
    logic            overflow;
    logic            full;
    logic            cts_m, cts_s;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_r;
    logic            ovr_r;
    logic [7:0]      head;
    logic            bit_end;

    assign head     = mem[rd_ptr];
    assign full     = (level_r == LW'(FIFO_DEPTH));
    assign push     = char_stb && !flush && (!full || pop);
    assign overflow = char_stb && !flush && full && !pop;
    assign bit_end  = (cnt == CW'(DIV - 1));

    assign prt_rdy = !full;
    assign busy    = (state != IDLE) || (level_r != '0);
    assign ovr     = ovr_r;
    assign level   = level_r;
    assign txd     = txd_r;

    // CTS idles deasserted out of reset so nothing starts before it is seen low
    always_ff @(posedge clk_p or negedge sys_init_n) begin
        if (!sys_init_n) begin
            cts_m <= 1'b1;
            cts_s <= 1'b1;
        end else begin
            cts_m <= cts_n;
            cts_s <= cts_m;
        end
    end

    always_ff @(posedge clk_p) begin
        if (push) mem[wr_ptr] <= char_i;
    end

    always_ff @(posedge clk_p or negedge sys_init_n) begin
        if (!sys_init_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            ovr_r   <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            ovr_r   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            if (overflow)     ovr_r <= 1'b1;
            else if (clr_ovr) ovr_r <= 1'b0;
        end
    end

    always_ff @(posedge clk_p or negedge sys_init_n) begin
        if (!sys_init_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shift  <= '0;
            txd_r  <= 1'b1;
            crdone <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            txd_r  <= txd_n;
            crdone <= crdone_n;
        end
    end

    // A LF at the head is sent twice: first as CR without popping, then itself
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        txd_n    = txd_r;
        crdone_n = crdone;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (level_r != '0 && !cts_s && !flush) begin
                    state_n = START;
                    cnt_n   = '0;
                    txd_n   = 1'b0;
                    if (CRLF != 0 && head == 8'h0A && !crdone) begin
                        shift_n  = 8'h0D;
                        crdone_n = 1'b1;
                    end else begin
                        shift_n  = (STRIP8 != 0) ? {1'b0, head[6:0]} : head;
                        pop      = 1'b1;
                        crdone_n = 1'b0;
                    end
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    txd_n    = shift[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                        shift_n  = {1'b0, shift[7:1]};
                        txd_n    = shift[1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) crdone_n = 1'b0;
    end

endmodule

// File: tb/tb_lp11_prt_tx.sv
// Directed bench for lp11_prt_tx with DIV=16 and a 4-entry FIFO.
module tb_lp11_prt_tx;

    logic       clk_p = 1'b0;
    logic       sys_init_n;
    logic [7:0] char_i;
    logic       char_stb;
    logic       flush;
    logic       clr_ovr;
    logic       cts_n;
    logic       prt_rdy;
    logic       busy;
    logic       ovr;
    logic [2:0] level;
    logic       txd;

    int checks = 0;
    int errors = 0;

    lp11_prt_tx #(
        .CLK_HZ(160), .BAUD(10), .FIFO_DEPTH(4), .CRLF(1), .STRIP8(1)
    ) dut (
        .clk_p(clk_p), .sys_init_n(sys_init_n), .char_i(char_i),
        .char_stb(char_stb), .flush(flush), .clr_ovr(clr_ovr), .cts_n(cts_n),
        .prt_rdy(prt_rdy), .busy(busy), .ovr(ovr), .level(level), .txd(txd)
    );

    always #5 clk_p = ~clk_p;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_p);
        #1;
    endtask

    // Waits for a start bit, then samples mid-bit; ok clears on bad framing or timeout
    task automatic rx_frame(output logic [7:0] d, output logic ok);
        int waited;
        waited = 0;
        ok = 1'b1;
        d = 8'h00;
        while (txd !== 1'b0 && waited < 400) begin
            tick(1);
            waited++;
        end
        if (txd !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        tick(8);
        if (txd !== 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick(16);
            d[j] = txd;
        end
        tick(16);
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        sys_init_n = 1'b0;
        char_i = 8'h00; char_stb = 1'b0; flush = 1'b0; clr_ovr = 1'b0; cts_n = 1'b1;
        #7;
        checks++;
        if ({txd, prt_rdy, busy, ovr, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset_state txd/rdy/busy/ovr/level=%b required 1100000",
                     {txd, prt_rdy, busy, ovr, level});
        end
        tick(2);
        sys_init_n = 1'b1;
        cts_n = 1'b0;
        tick(5);
    endtask

    task automatic test_single();
        logic exp_bits [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        tick(5);
        char_i = 8'h41; char_stb = 1'b1;
        tick(1);
        char_stb = 1'b0;
        checks++;
        if (level !== 3'd1 || txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_queued level=%0d txd=%b required 1 1", level, txd);
        end
        tick(1);
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_start txd=%b busy=%b level=%0d required 0 1 0", txd, busy, level);
        end
        tick(8);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (txd !== exp_bits[k]) begin
                errors++;
                $display("[TB] FAIL single_bit%0d txd=%b required %b", k, txd, exp_bits[k]);
            end
            if (k < 9) tick(16);
        end
        tick(7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_busy_stop busy=%b required 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_done busy=%b txd=%b required 0 1", busy, txd);
        end
    endtask

    task automatic test_crlf();
        logic [7:0] d;
        logic ok;
        tick(5);
        char_i = 8'h0A; char_stb = 1'b1;
        tick(1);
        char_stb = 1'b0;
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL crlf_level0 level=%0d required 1", level);
        end
        rx_frame(d, ok);
        checks++;
        if (!ok || d !== 8'h0D || level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL crlf_cr data=%h ok=%b level=%0d required 0d 1 1", d, ok, level);
        end
        rx_frame(d, ok);
        checks++;
        if (!ok || d !== 8'h0A || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL crlf_lf data=%h ok=%b level=%0d required 0a 1 0", d, ok, level);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ob [5] = '{8'hB1, 8'h32, 8'h33, 8'h34, 8'h35};
        logic [7:0] ex [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
        logic [7:0] d;
        logic ok;
        int lows;
        cts_n = 1'b1;
        tick(20);
        for (int i = 0; i < 5; i++) begin
            char_i = ob[i]; char_stb = 1'b1;
            tick(1);
            if (i == 3) begin
                checks++;
                if (prt_rdy !== 1'b0 || level !== 3'd4 || ovr !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_full rdy=%b level=%0d ovr=%b required 0 4 0", prt_rdy, level, ovr);
                end
            end
        end
        char_stb = 1'b0;
        checks++;
        if (ovr !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL ovf_drop ovr=%b level=%0d required 1 4", ovr, level);
        end
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (txd !== 1'b1) lows++;
            tick(1);
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("[TB] FAIL ovf_cts_hold low_samples=%0d required 0", lows);
        end
        cts_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_frame(d, ok);
            checks++;
            if (!ok || d !== ex[i]) begin
                errors++;
                $display("[TB] FAIL ovf_frame%0d data=%h ok=%b required %h 1", i, d, ok, ex[i]);
            end
        end
        checks++;
        if (ovr !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL ovf_sticky ovr=%b level=%0d required 1 0", ovr, level);
        end
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear ovr=%b required 0", ovr);
        end
    endtask

    task automatic test_cts_mid();
        int lows;
        tick(20);
        char_i = 8'h55; char_stb = 1'b1;
        tick(1);
        char_i = 8'h66;
        tick(1);
        char_stb = 1'b0;
        checks++;
        if (txd !== 1'b0 || level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL cts_start txd=%b level=%0d required 0 1", txd, level);
        end
        tick(40);
        cts_n = 1'b1;
        tick(80);
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cts_bit6 txd=%b required 1", txd);
        end
        tick(16);
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cts_bit7 txd=%b required 0", txd);
        end
        tick(16);
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cts_stop txd=%b required 1", txd);
        end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (txd !== 1'b1) lows++;
            tick(1);
        end
        checks++;
        if (lows != 0 || level !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cts_held lows=%0d level=%0d busy=%b required 0 1 1", lows, level, busy);
        end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        checks++;
        if (level !== 3'd0 || busy !== 1'b0 || prt_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cts_flush level=%0d busy=%b rdy=%b required 0 0 1", level, busy, prt_rdy);
        end
    endtask

    task automatic test_reset_mid();
        int lows;
        cts_n = 1'b0;
        tick(20);
        char_i = 8'h55; char_stb = 1'b1;
        tick(1);
        char_i = 8'h77;
        tick(1);
        char_stb = 1'b0;
        tick(40);
        checks++;
        if (txd !== 1'b0 || level !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_pre txd=%b level=%0d busy=%b required 0 1 1", txd, level, busy);
        end
        sys_init_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || level !== 3'd0 || prt_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid txd=%b level=%0d rdy=%b busy=%b required 1 0 1 0",
                     txd, level, prt_rdy, busy);
        end
        #2;
        sys_init_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_glitch lows=%0d busy=%b required 0 0", lows, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] d;
        logic ok;
        cts_n = 1'b1;
        tick(5);
        for (int i = 0; i < 4; i++) begin
            char_i = ex[i]; char_stb = 1'b1;
            tick(1);
        end
        char_stb = 1'b0;
        checks++;
        if (level !== 3'd4 || prt_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full level=%0d rdy=%b required 4 0", level, prt_rdy);
        end
        cts_n = 1'b0;
        tick(2);
        char_i = 8'h55; char_stb = 1'b1;
        tick(1);
        char_stb = 1'b0;
        checks++;
        if (level !== 3'd4 || ovr !== 1'b0 || txd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_pushpop level=%0d ovr=%b txd=%b required 4 0 0", level, ovr, txd);
        end
        for (int i = 0; i < 5; i++) begin
            rx_frame(d, ok);
            checks++;
            if (!ok || d !== ex[i]) begin
                errors++;
                $display("[TB] FAIL b2b_frame%0d data=%h ok=%b required %h 1", i, d, ok, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_crlf();
        test_overflow();
        test_cts_mid();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
